logic_scan_ctrl: RTL

Upstream stimulus-and-capture stage for the 3-input combinational logic_function block (F = A'B + B'C' + A'BC). On a start request it drives all eight {A,B,C} combinations into the block in ascending order. After a programmable settle time for each combination, it samples F. It assembles the 8-entry truth table and compares it against an expected constant, then reports pass/fail with a per-vector mismatch mask. It is used as a built-in self-test wrapper around combinational blocks in this codebase.

---
 rtl/logic_scan_ctrl_pkg.sv | 31 +++
 rtl/logic_function.sv | 12 +
 rtl/logic_scan_ctrl_settle_timer.sv | 35 +++
 rtl/logic_scan_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/logic_scan_ctrl_pkg.sv
// Shared types and constants for the logic_scan_ctrl self-test wrapper.
// Holds the FSM state encoding, vector geometry and the golden truth table.
package logic_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scanState_e;

  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = 3;

  localparam logic [7:0] LOGIC_FUNCTION_GOLDEN_TT = 8'h1D;

  // Index of the lowest set bit; 0 for an all-zero mask.
  function automatic logic [VEC_W-1:0] lowestSetIdx(input logic [NUM_VECTORS-1:0] mask);
    logic [VEC_W-1:0] idx;
    idx = 3'd0;
    for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = VEC_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/logic_function.sv
// Combinational block under test: F = A'B + B'C' + A'BC.
// Golden truth table (bit i = F for {A,B,C} = i) is 8'h1D.
module logic_function (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic f
);

  assign f = (~a & b) | (~b & ~c) | (~a & b & c);

endmodule

// File: rtl/logic_scan_ctrl_settle_timer.sv
// Loadable 8-bit down-counter with a registered zero flag.
// Load has priority over decrement; the count saturates at zero.
module settle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             isZero
);

  logic [WIDTH-1:0] count_r;
  logic             zero_r;

  // Counter and zero flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
      zero_r  <= 1'b1;
    end else if (load) begin
      count_r <= loadValue;
      zero_r  <= (loadValue == '0);
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - 1'b1;
      zero_r  <= (count_r == WIDTH'(1));
    end
  end

  assign count  = count_r;
  assign isZero = zero_r;

endmodule

// File: rtl/logic_scan_ctrl.sv
// Built-in self-test wrapper: walks all {A,B,C} vectors, samples F after a
// settle time, and reports the captured truth table against EXP_TT.
module logic_scan_ctrl
  import logic_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXP_TT        = LOGIC_FUNCTION_GOLDEN_TT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       f_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] truth_table,
  output logic [7:0] mismatch_mask,
  output logic [2:0] first_fail_idx
);

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255)) begin : gIllegalSettle
    $error("logic_scan_ctrl: SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  scanState_e       state_r, nextState_s;
  logic [VEC_W-1:0] vecIdx_r;
  logic [7:0]       shadow_r;
  logic             busy_r, done_r, pass_r;
  logic [7:0]       truthTable_r, mismatch_r;
  logic [2:0]       firstFail_r;
  logic             timerLoad_s, timerDec_s, timerZero_s, commit_s;
  logic [7:0]       timerCount_s;

  settle_timer #(.WIDTH(8)) uSettleTimer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timerLoad_s),
    .loadValue(SETTLE_LOAD),
    .dec      (timerDec_s),
    .count    (timerCount_s),
    .isZero   (timerZero_s)
  );

  // Abort in DONE suppresses both the done pulse and the result update.
  assign commit_s = (state_r == DONE) && !abort;

  // Next-state and timer control
  always_comb begin
    nextState_s = state_r;
    timerLoad_s = 1'b0;
    timerDec_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (abort) begin
          nextState_s = IDLE;
        end else if (start) begin
          nextState_s = SETTLE;
          timerLoad_s = 1'b1;
        end else begin
          nextState_s = IDLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          nextState_s = IDLE;
        end else if (timerZero_s) begin
          nextState_s = SAMPLE;
        end else begin
          timerDec_s = 1'b1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          nextState_s = IDLE;
        end else if (vecIdx_r == 3'd7) begin
          nextState_s = DONE;
        end else begin
          nextState_s = SETTLE;
          timerLoad_s = 1'b1;
        end
      end
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Vector index, shadow table and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vecIdx_r <= 3'd0;
      shadow_r <= 8'h00;
      busy_r   <= 1'b0;
    end else if (nextState_s == IDLE) begin
      vecIdx_r <= 3'd0;
      busy_r   <= 1'b0;
    end else if (state_r == IDLE) begin
      vecIdx_r <= 3'd0;
      shadow_r <= 8'h00;
      busy_r   <= 1'b1;
    end else if (state_r == SAMPLE) begin
      shadow_r[vecIdx_r] <= f_in;
      if (vecIdx_r != 3'd7) begin
        vecIdx_r <= vecIdx_r + 3'd1;
      end
    end
  end

  // Result registers, committed only on a non-aborted DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      truthTable_r <= 8'h00;
      mismatch_r   <= 8'h00;
      firstFail_r  <= 3'd0;
    end else begin
      done_r <= commit_s;
      if (commit_s) begin
        truthTable_r <= shadow_r;
        mismatch_r   <= shadow_r ^ EXP_TT;
        pass_r       <= (shadow_r == EXP_TT);
        firstFail_r  <= lowestSetIdx(shadow_r ^ EXP_TT);
      end
    end
  end

  assign {a, b, c}      = vecIdx_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign truth_table    = truthTable_r;
  assign mismatch_mask  = mismatch_r;
  assign first_fail_idx = firstFail_r;

endmodule
